// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: round-robin arbiter and sequencer for the shared 16-bit register bus.
// Each granted transfer drives the bus mux select for the whole transfer, then pulses the
// destination load enables for one cycle and acks the owner.
// Optional feature macro: BUS_SETTLE_EN inserts SETTLE_CYCLES bus-settle cycles between
// SEL and LOAD.
module bus_transfer_ctrl #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    src_sel,
    input  logic [11*NREQ-1:0]   dst_mask,
    output logic [3:0]           bus_sel,
    output logic [10:0]          ld_en,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic                 busy
);

    localparam int unsigned PW = $clog2(NREQ);

    // Reject out-of-range configurations at elaboration
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ must be in 2..8");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

`ifdef BUS_SETTLE_EN
    typedef enum logic [1:0] {StIdle, StSel, StSettle, StLoad} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSel, StLoad} state_e;
`endif

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic [3:0]    src_q, src_d;
    logic [10:0]   dst_q, dst_d;
`ifdef BUS_SETTLE_EN
    logic [3:0]    cnt_q, cnt_d;
`endif

    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic [3:0]    src_pick;
    logic [10:0]   dst_pick;
    logic [NREQ-1:0] win_oh;
    logic          src_ok;

    // Round-robin search: first active request at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        sum   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Select the winner's source code and destination mask for latching
    always_comb begin
        src_pick = '0;
        dst_pick = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick == PW'(i)) begin
                src_pick = src_sel[4*i +: 4];
                dst_pick = dst_mask[11*i +: 11];
            end
        end
    end

    // One-hot decode of the latched owner
    always_comb begin
        win_oh = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            win_oh[i] = (win_q == PW'(i));
        end
    end

    // State, pointer and transfer latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
`ifdef BUS_SETTLE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
`ifdef BUS_SETTLE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic; inputs are only sampled in IDLE
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        src_d   = src_q;
        dst_d   = dst_q;
`ifdef BUS_SETTLE_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d   = pick;
                    src_d   = src_pick;
                    dst_d   = dst_pick;
                    ptr_d   = (pick == PW'(NREQ-1)) ? '0 : pick + 1'b1;
                    state_d = StSel;
                end
            end
            StSel: begin
`ifdef BUS_SETTLE_EN
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                state_d = StSettle;
`else
                state_d = StLoad;
`endif
            end
`ifdef BUS_SETTLE_EN
            StSettle: begin
                if (cnt_q == 4'd0) begin
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Valid register codes are 0..8 and 10
    assign src_ok = (src_q <= 4'd8) || (src_q == 4'd10);

    // Outputs decoded from state so reset clears them immediately
    always_comb begin
        bus_sel = '0;
        ld_en   = '0;
        grant   = '0;
        ack     = '0;
        err     = 1'b0;
        busy    = 1'b0;
        if (state_q != StIdle) begin
            busy    = 1'b1;
            bus_sel = src_q;
            grant   = win_oh;
        end
        if (state_q == StLoad) begin
            ack = win_oh;
            if (src_ok) begin
                // Code 9 has no register behind it
                ld_en = dst_q & 11'h5FF;
            end else begin
                err = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Self-checking bench for bus_transfer_ctrl: a transfer-level reference model checked every
// cycle, plus directed literal expectations for the main scenarios.
module tb_bus_transfer_ctrl;

    localparam int N = 4;
    localparam int S = 3;
`ifdef BUS_SETTLE_EN
    localparam int L = 3 + S;
`else
    localparam int L = 3;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [4*N-1:0]  src_sel = '0;
    logic [11*N-1:0] dst_mask = '0;
    logic [3:0]    bus_sel;
    logic [10:0]   ld_en;
    logic [N-1:0]  grant;
    logic [N-1:0]  ack;
    logic          err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    bus_transfer_ctrl #(.NREQ(N), .SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .src_sel  (src_sel),
        .dst_mask (dst_mask),
        .bus_sel  (bus_sel),
        .ld_en    (ld_en),
        .grant    (grant),
        .ack      (ack),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transfer level) ----------------
    // m_c: 0 when idle, otherwise cycle number within the current transfer (1..L-1)
    int          m_c = 0;
    int          m_w = 0;
    int          m_ptr = 0;
    logic [3:0]  m_src = '0;
    logic [10:0] m_dst = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Update the model on each sampling edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_c   <= 0;
            m_ptr <= 0;
        end else if (m_c == 0) begin
            if (rr_pick(req, m_ptr) >= 0) begin
                m_w   <= rr_pick(req, m_ptr);
                m_src <= src_sel[4*rr_pick(req, m_ptr) +: 4];
                m_dst <= dst_mask[11*rr_pick(req, m_ptr) +: 11];
                m_ptr <= (rr_pick(req, m_ptr) + 1) % N;
                m_c   <= 1;
            end
        end else if (m_c == L - 1) begin
            m_c <= 0;
        end else begin
            m_c <= m_c + 1;
        end
    end

    // Compare DUT outputs with the model away from the active edge
    always @(negedge clk) begin
        logic [3:0]   e_bus;
        logic [10:0]  e_ld;
        logic [N-1:0] e_grant, e_ack;
        logic         e_err, e_busy, ok;
        e_bus = '0; e_ld = '0; e_grant = '0; e_ack = '0; e_err = 1'b0; e_busy = 1'b0;
        ok = (m_src <= 4'd8) || (m_src == 4'd10);
        if (m_c != 0) begin
            e_busy  = 1'b1;
            e_bus   = m_src;
            e_grant = N'(1) << m_w;
        end
        if (m_c == L - 1) begin
            e_ack = N'(1) << m_w;
            if (ok) e_ld = m_dst & ~(11'(1) << 9);
            else    e_err = 1'b1;
        end
        chk("model_bus_sel", 32'(bus_sel), 32'(e_bus));
        chk("model_ld_en",   32'(ld_en),   32'(e_ld));
        chk("model_grant",   32'(grant),   32'(e_grant));
        chk("model_ack",     32'(ack),     32'(e_ack));
        chk("model_err",     32'(err),     32'(e_err));
        chk("model_busy",    32'(busy),    32'(e_busy));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [3:0] s, input logic [10:0] d);
        src_sel[4*i +: 4]   = s;
        dst_mask[11*i +: 11] = d;
    endtask

    // Run one single-requester transfer on requester 0 up to the LOAD cycle
    task automatic run_to_load(input logic [3:0] s, input logic [10:0] d);
        set_req(0, s, d);
        req = 4'b0001;
        tick();                        // SEL
        req = '0;
        for (int i = 0; i < L - 2; i++) tick();   // settle cycles then LOAD
    endtask

    logic [N-1:0] rr_exp [6];
    logic [63:0]  rnd;

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001; rr_exp[5] = 4'b0010;

        // Reset state
        tick();
        chk("reset_busy",  32'(busy),  0);
        chk("reset_grant", 32'(grant), 0);
        chk("reset_bus",   32'(bus_sel), 0);
        reset = 1'b0;
        tick();

        // Single transfer: AC -> R1
        set_req(0, 4'd8, 11'h004);
        req = 4'b0001;
        tick();
        req = '0;
        chk("single_sel_bus",   32'(bus_sel), 8);
        chk("single_sel_grant", 32'(grant),   1);
        chk("single_sel_ld",    32'(ld_en),   0);
        chk("single_sel_busy",  32'(busy),    1);
        for (int i = 0; i < L - 3; i++) begin
            tick();
            chk("single_settle_ld",  32'(ld_en),   0);
            chk("single_settle_bus", 32'(bus_sel), 8);
        end
        tick();
        chk("single_load_ld",  32'(ld_en), 32'h004);
        chk("single_load_ack", 32'(ack),   1);
        chk("single_load_err", 32'(err),   0);
        tick();
        chk("single_idle_busy", 32'(busy),  0);
        chk("single_idle_ld",   32'(ld_en), 0);

        // Round robin with all requesting, then 1010 from ptr=2
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'(i), 11'(1) << i);
        req = 4'b1111;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk("rr_all_grant", 32'(grant), 32'(rr_exp[g]));
            for (int i = 0; i < L - 1; i++) tick();
        end
        req = 4'b1010;
        tick();
        chk("rr_1010_first", 32'(grant), 32'h8);
        for (int i = 0; i < L - 1; i++) tick();
        tick();
        chk("rr_1010_second", 32'(grant), 32'h2);
        req = '0;
        for (int i = 0; i < L - 1; i++) tick();

        // Invalid sources
        run_to_load(4'd9, 11'h7FF);
        chk("inv9_err", 32'(err), 1);
        chk("inv9_ack", 32'(ack), 1);
        chk("inv9_ld",  32'(ld_en), 0);
        tick();
        run_to_load(4'd15, 11'h7FF);
        chk("inv15_err", 32'(err), 1);
        chk("inv15_ack", 32'(ack), 1);
        chk("inv15_ld",  32'(ld_en), 0);
        tick();

        // Bit 9 masking
        run_to_load(4'd2, 11'h600);
        chk("mask9_ld",  32'(ld_en), 32'h400);
        chk("mask9_err", 32'(err), 0);
        tick();

        // Reset during SEL aborts, then requester 0 is re-granted from ptr 0
        do_reset();
        set_req(0, 4'd3, 11'h008);
        set_req(1, 4'd4, 11'h010);
        req = 4'b0011;
        tick();
        chk("abort_sel_grant", 32'(grant), 1);
        reset = 1'b1;
        #1;
        chk("abort_grant", 32'(grant),   0);
        chk("abort_busy",  32'(busy),    0);
        chk("abort_bus",   32'(bus_sel), 0);
        chk("abort_ack",   32'(ack),     0);
        chk("abort_ld",    32'(ld_en),   0);
        #1;
        reset = 1'b0;
        tick();
        chk("abort_regrant", 32'(grant), 1);
        req = '0;
        for (int i = 0; i < L - 1; i++) tick();

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 600; c++) begin
            req = N'($urandom_range(0, 15));
            src_sel = 16'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) != 0) src_sel[4*i +: 4] = 4'($urandom_range(0, 10));
            end
            rnd = {$urandom, $urandom};
            dst_mask = rnd[43:0];
            tick();
        end
        req = '0;
        for (int i = 0; i < L + 2; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
